// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog controller: FSM states, register
// addresses, STATUS bit positions and the STATUS word packer.
package wdt_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_SETTLING = 3'd1,
        ST_ARMED    = 3'd2,
        ST_KICKING  = 3'd3,
        ST_EXPIRED  = 3'd4
    } wdt_state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_TOCNT  = 2'd1;
    localparam logic [1:0] ADDR_KICK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int STAT_TIMEOUT = 0;
    localparam int STAT_CFG_ERR = 1;
    localparam int STAT_KICKING = 2;

    // Packs the STATUS read word; unused bits read as zero.
    function automatic logic [31:0] status_word(input logic timeout,
                                                input logic cfg_err,
                                                input logic kicking);
        return {29'd0, kicking, cfg_err, timeout};
    endfunction

endpackage

// File: rtl/wdt_ctrl_if.sv
// CPU register bus of the watchdog controller: one write port, one
// combinational read port.
interface wdt_ctrl_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (output wr_en, output wr_addr, output wr_data,
                    output rd_addr, input rd_data);
    modport slave  (input wr_en, input wr_addr, input wr_data,
                    input rd_addr, output rd_data);
endinterface

// File: rtl/wdt_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_r;

    // Two-stage capture of the asynchronous input into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end
endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog controller: CPU-programmable enable/kick/timeout-count levels
// toward the watchdog and a sticky timeout interrupt back from it.
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter int LIVE_HOLD = 4,
    parameter int SETTLE    = 4
) (
    input  logic        clk,
    input  logic        rst,
    wdt_ctrl_if.slave   bus,
    input  logic        WTO_in,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    output logic        wdt_irq,
    output logic        wdt_busy
);
    localparam int CNT_MAX = (LIVE_HOLD > SETTLE) ? LIVE_HOLD : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(LIVE_HOLD - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    wdt_state_e   state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [31:0]  tocnt_r, tocnt_s;
    logic         timeout_r, timeout_s;
    logic         cfg_err_r, cfg_err_s;
    logic         en_err_s, tocnt_err_s;
    logic         wden_r, wdlive_r;
    logic         wto_sync_s, wto_prev_r, wto_rise_r;
    logic         wr_ctrl_s, wr_tocnt_s, wr_kick_s, wr_status_s;
    logic         en_wr1_s, en_wr0_s, en_s;
    logic         clr_timeout_s, clr_cfg_err_s;

    sync_2ff u_wto_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (WTO_in),
        .q     (wto_sync_s)
    );

    assign wr_ctrl_s     = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
    assign wr_tocnt_s    = bus.wr_en && (bus.wr_addr == ADDR_TOCNT);
    assign wr_kick_s     = bus.wr_en && (bus.wr_addr == ADDR_KICK);
    assign wr_status_s   = bus.wr_en && (bus.wr_addr == ADDR_STATUS);
    assign en_wr1_s      = wr_ctrl_s && bus.wr_data[0];
    assign en_wr0_s      = wr_ctrl_s && !bus.wr_data[0];
    assign clr_timeout_s = wr_status_s && bus.wr_data[STAT_TIMEOUT];
    assign clr_cfg_err_s = wr_status_s && bus.wr_data[STAT_CFG_ERR];
    assign en_s          = (state_r == ST_SETTLING) || (state_r == ST_ARMED) ||
                           (state_r == ST_KICKING);

    // Next state and settle/hold counter; a timeout outranks en=0, which outranks a kick.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        en_err_s = 1'b0;
        case (state_r)
            ST_DISABLED: begin
                if (en_wr1_s) begin
                    if (tocnt_r == 32'd0) begin
                        en_err_s = 1'b1;
                    end else begin
                        state_s = ST_SETTLING;
                        cnt_s   = SETTLE_LD;
                    end
                end else begin
                    state_s = ST_DISABLED;
                end
            end
            ST_SETTLING: begin
                if (en_wr0_s) begin
                    state_s = ST_DISABLED;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_ARMED;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_ARMED: begin
                if (wto_rise_r) begin
                    state_s = ST_EXPIRED;
                end else if (en_wr0_s) begin
                    state_s = ST_DISABLED;
                end else if (wr_kick_s) begin
                    state_s = ST_KICKING;
                    cnt_s   = HOLD_LD;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_KICKING: begin
                if (wto_rise_r) begin
                    state_s = ST_EXPIRED;
                end else if (en_wr0_s) begin
                    state_s = ST_DISABLED;
                end else if (wr_kick_s) begin
                    cnt_s = HOLD_LD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_ARMED;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_EXPIRED: begin
                if (clr_timeout_s && !wto_rise_r) begin
                    state_s = ST_DISABLED;
                end else begin
                    state_s = ST_EXPIRED;
                end
            end
            default: begin
                state_s = ST_DISABLED;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // TOCNT acceptance and the sticky STATUS bits; a hardware set beats a w1c clear.
    always_comb begin
        tocnt_s     = tocnt_r;
        tocnt_err_s = 1'b0;
        if (wr_tocnt_s) begin
            if ((state_r == ST_DISABLED) && (bus.wr_data != 32'd0)) begin
                tocnt_s = bus.wr_data;
            end else begin
                tocnt_err_s = 1'b1;
            end
        end else begin
            tocnt_s = tocnt_r;
        end
        timeout_s = wto_rise_r | (timeout_r & !clr_timeout_s);
        cfg_err_s = en_err_s | tocnt_err_s | (cfg_err_r & !clr_cfg_err_s);
    end

    // Control state, registers and the watchdog-facing levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_DISABLED;
            cnt_r     <= CNT_ZERO;
            tocnt_r   <= 32'd0;
            timeout_r <= 1'b0;
            cfg_err_r <= 1'b0;
            wden_r    <= 1'b0;
            wdlive_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            tocnt_r   <= tocnt_s;
            timeout_r <= timeout_s;
            cfg_err_r <= cfg_err_s;
            wden_r    <= (state_s == ST_ARMED) || (state_s == ST_KICKING);
            wdlive_r  <= (state_s == ST_KICKING);
        end
    end

    // Registered rising-edge detect on the synchronised timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wto_prev_r <= 1'b0;
            wto_rise_r <= 1'b0;
        end else begin
            wto_prev_r <= wto_sync_s;
            wto_rise_r <= wto_sync_s & !wto_prev_r;
        end
    end

    // Combinational register read mux.
    always_comb begin
        case (bus.rd_addr)
            ADDR_CTRL:   bus.rd_data = {31'd0, en_s};
            ADDR_TOCNT:  bus.rd_data = tocnt_r;
            ADDR_KICK:   bus.rd_data = 32'd0;
            ADDR_STATUS: bus.rd_data = status_word(timeout_r, cfg_err_r,
                                                   state_r == ST_KICKING);
            default:     bus.rd_data = 32'd0;
        endcase
    end

    assign WDEN     = wden_r;
    assign WDLIVE   = wdlive_r;
    assign WTOCNT   = tocnt_r;
    assign wdt_irq  = timeout_r;
    assign wdt_busy = (state_r != ST_DISABLED);

endmodule

// File: doc/wdt_ctrl.md
Name: wdt_ctrl

Overview:
- System-clock-side controller that programs and services the watchdog timer.
- Exposes a 4-register write/read interface to the CPU bus.
- Drives the watchdog's enable, kick and timeout-count inputs as registered, CDC-safe levels.
- Synchronises the watchdog's timeout back into clk and raises a sticky interrupt.

Parameters:
- LIVE_HOLD, 4, cycles WDLIVE is held high per kick (≥2 so the clk2 two-flop sync always catches it); min 1.
- SETTLE, 4, cycles WTOCNT is held stable before WDEN asserts (quasi-static multi-bit CDC); min 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-low (asserted when 0)
- wr_en  in  1  register write strobe
- wr_addr  in  2  write address
- wr_data  in  32  write data
- rd_addr  in  2  read address
- rd_data  out  32  combinational read data
- WTO_in  in  1  timeout from watchdog (clk2 domain, asynchronous here)
- WDEN  out  1  watchdog enable, registered
- WDLIVE  out  1  kick level, registered
- WTOCNT  out  32  timeout count, registered
- wdt_irq  out  1  level interrupt; equals STATUS.timeout
- wdt_busy  out  1  state != DISABLED

Behaviour:
- Reset: all outputs 0, all registers 0, sync flops 0, state DISABLED.
- Register map:
  - 0 CTRL: bit0 en.
  - 1 TOCNT: 32-bit count.
  - 2 KICK: any write; data ignored; reads 0.
  - 3 STATUS: bit0 timeout, bit1 cfg_err, bit2 kicking. Bits 0/1 are sticky, write-1-to-clear; bit2 is read-only.
  - Unused read bits return 0.
- TOCNT write:
  - Accepted only in DISABLED with wr_data != 0; WTOCNT updates next cycle.
  - Otherwise ignored and cfg_err set.
- WTO sync: 2-flop synchroniser, then a third flop for rising-edge detection.
  - WTO_in sampled high at edge n → wto_rise at edge n+2 → state EXPIRED at edge n+3.
- FSM states: DISABLED, SETTLING, ARMED, KICKING, EXPIRED.
- DISABLED (WDEN=0, WDLIVE=0):
  - CTRL write en=1 → SETTLING, settle counter = SETTLE-1.
  - If WTOCNT==0, the en=1 write instead sets cfg_err, stays DISABLED, and leaves en=0.
- SETTLING (WDEN=0):
  - Counter decrements; at 0 → ARMED; WDEN rises on that transition edge.
  - en=0 write → DISABLED.
  - KICK write ignored.
- ARMED (WDEN=1):
  - KICK write → KICKING; WDLIVE=1 from next edge; hold counter = LIVE_HOLD-1.
  - en=0 write → DISABLED; WDEN=0 next edge.
- KICKING (WDEN=1, WDLIVE=1):
  - Counter decrements; at 0 → ARMED, WDLIVE=0.
  - KICK write reloads the counter (extends the pulse; no extra pulse).
  - en=0 → DISABLED, WDLIVE=0.
- EXPIRED (WDEN=0, WDLIVE=0, en cleared by hardware):
  - Entered from ARMED/KICKING on wto_rise; sets timeout.
  - Stays until timeout is cleared via STATUS w1c → DISABLED. A new en=1 write is then required.
- wto_rise in DISABLED/SETTLING: sets timeout (spurious), no state change.
- Priority in a single cycle:
  - wto_rise > en=0 write > KICK write.
  - A hardware set of a sticky bit beats a w1c clear in the same cycle.
- Only one write per cycle (single address), so there is no register write collision.
- Async reset mid-kick: WDLIVE and WDEN drop immediately.

Decomposition:
- wdt_pkg:
  - State enum (typedef logic [2:0]).
  - Register address localparams (ADDR_CTRL=0, ADDR_TOCNT=1, ADDR_KICK=2, ADDR_STATUS=3).
  - STATUS bit indices.
- Sub-module sync_2ff (1-bit, async active-low reset): instanced for WTO_in. The edge-detect flop stays in wdt_ctrl.

Test Plan:
- Reset then read all four addresses → all 0. WDEN=WDLIVE=0, wdt_irq=0.
- Write TOCNT=100, then CTRL=1 → WDEN rises exactly SETTLE=4 cycles after the write's accept edge; WTOCNT=100 throughout.
- ARMED, KICK write → WDLIVE high exactly 4 cycles. A second KICK at cycle 2 of that pulse → high 6 cycles total, single pulse.
- ARMED, TOCNT=5 write → WTOCNT stays 100, STATUS=0x2. Write STATUS=0x2 → STATUS=0.
- ARMED, WTO_in high at edge n → wdt_irq=1 and WDEN=0 at edge n+3, CTRL reads 0. Write STATUS=1 → DISABLED, wdt_busy=0.
- KICK write coinciding with wto_rise → EXPIRED, WDLIVE never asserts. TOCNT=0 with en=1 → cfg_err set, WDEN stays 0.
